// File: rtl/fetch_predictor.sv
// rtl/fetch_predictor.sv - single-stage instruction fetch with static JAL and 2-bit BHT branch prediction
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_addr             fetch address (the PC register)
//   imem_rdata            instruction at imem_addr, combinational read
//   out_valid/out_ready   registered fetch packet handshake
//   out_pc, out_inst      packet PC and instruction word
//   out_pred_taken        prediction applied to the packet
//   out_pred_pc           address fetched after the packet
//   redirect_valid/_pc    execute-stage flush to a corrected address
//   upd_valid/_pc/_taken  resolved conditional branch outcome for BHT training

module fetch_predictor #(
    parameter int          XLEN        = 32,
    parameter int          BHT_ENTRIES = 64,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_pred_taken,
    output logic [XLEN-1:0] out_pred_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_inst_q, out_inst_d;
    logic            out_pred_taken_q, out_pred_taken_d;
    logic [XLEN-1:0] out_pred_pc_q, out_pred_pc_d;
    logic [1:0]      bht_q [BHT_ENTRIES];
    logic [1:0]      bht_d [BHT_ENTRIES];

    logic [6:0]      opcode;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] j_imm;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
    logic            advance;

    // Only the index bits of the update PC select a counter.
    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

    assign opcode     = imem_rdata[6:0];
    assign b_imm      = {{(XLEN-12){imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                         imem_rdata[11:8], 1'b0};
    assign j_imm      = {{(XLEN-20){imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                         imem_rdata[30:21], 1'b0};
    assign lookup_idx = pc_q[IDX_W+1:2];
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign advance    = !out_valid_q || out_ready;

    // Lookup reads bht_q, so a same-cycle update to this index is seen only next cycle.
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc_q + XLEN'(4);
        if (opcode == OP_JAL) begin
            pred_taken = 1'b1;
            pred_pc    = pc_q + j_imm;
        end else if (opcode == OP_BRANCH && bht_q[lookup_idx][1]) begin
            pred_taken = 1'b1;
            pred_pc    = pc_q + b_imm;
        end
    end

    always_comb begin
        pc_d             = pc_q;
        out_valid_d      = out_valid_q;
        out_pc_d         = out_pc_q;
        out_inst_d       = out_inst_q;
        out_pred_taken_d = out_pred_taken_q;
        out_pred_pc_d    = out_pred_pc_q;
        if (redirect_valid) begin
            // Flush: the word currently on imem_rdata belongs to the wrong path.
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
        end else if (advance) begin
            pc_d             = pred_pc;
            out_valid_d      = 1'b1;
            out_pc_d         = pc_q;
            out_inst_d       = imem_rdata;
            out_pred_taken_d = pred_taken;
            out_pred_pc_d    = pred_pc;
        end
    end

    always_comb begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (upd_valid) begin
            if (upd_taken) begin
                if (bht_q[upd_idx] != 2'b11) begin
                    bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
                end
            end else begin
                if (bht_q[upd_idx] != 2'b00) begin
                    bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            out_valid_q      <= 1'b0;
            out_pc_q         <= '0;
            out_inst_q       <= '0;
            out_pred_taken_q <= 1'b0;
            out_pred_pc_q    <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            pc_q             <= pc_d;
            out_valid_q      <= out_valid_d;
            out_pc_q         <= out_pc_d;
            out_inst_q       <= out_inst_d;
            out_pred_taken_q <= out_pred_taken_d;
            out_pred_pc_q    <= out_pred_pc_d;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    assign imem_addr      = pc_q;
    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_inst       = out_inst_q;
    assign out_pred_taken = out_pred_taken_q;
    assign out_pred_pc    = out_pred_pc_q;

endmodule

// File: doc/fetch_predictor.md
FETCH_PREDICTOR -- requirements
Module: fetch_predictor

Interface
REQ-001 Parameter XLEN, default 32; datapath and PC width.
REQ-002 Parameter BHT_ENTRIES, default 64; branch history table depth, power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 imem_addr  out  XLEN  fetch address; equals the PC register.
REQ-007 imem_rdata  in  32  instruction at imem_addr, valid in the same cycle (combinational read).
REQ-008 out_valid  out  1  registered fetch packet valid.
REQ-009 out_ready  in  1  downstream accepts the packet.
REQ-010 out_pc  out  XLEN  PC of the packet.
REQ-011 out_inst  out  32  instruction word of the packet.
REQ-012 out_pred_taken  out  1  prediction applied to the packet.
REQ-013 out_pred_pc  out  XLEN  address fetched after the packet.
REQ-014 redirect_valid  in  1  execute-stage mispredict or flush.
REQ-015 redirect_pc  in  XLEN  corrected fetch address.
REQ-016 upd_valid  in  1  resolved conditional branch report.
REQ-017 upd_pc  in  XLEN  PC of the resolved branch.
REQ-018 upd_taken  in  1  actual branch outcome.

Function
REQ-019 Opcodes SHALL use the RV32I encodings: BRANCH 7'b1100011, JAL 7'b1101111; all other opcodes are non-control.
REQ-020 Immediates SHALL be sign-extended to XLEN: B-imm {inst[31], inst[7], inst[30:25], inst[11:8], 0}; J-imm {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
REQ-021 BHT index SHALL be pc[log2(BHT_ENTRIES)+1:2]; each entry is a 2-bit saturating counter.
REQ-022 Prediction SHALL be: JAL always taken, target pc+J-imm; BRANCH taken iff counter >= 2'b10, target pc+B-imm; all others, including JALR, not taken with target pc+4.
REQ-023 Target arithmetic SHALL be modulo 2^XLEN (wrap-around, no trap).
REQ-024 advance = !out_valid || out_ready.
REQ-025 On an advance cycle without redirect: packet registers <= {1, pc, imem_rdata, pred_taken, pred_pc}; pc <= pred_pc. Latency is one cycle from imem_addr to out_valid.
REQ-026 On a non-advance cycle without redirect, pc and all packet registers SHALL hold; imem_addr stays stable.
REQ-027 On redirect_valid=1, regardless of out_ready: pc <= redirect_pc; out_valid <= 0; the current imem_rdata is discarded.
REQ-028 On upd_valid=1: the counter at upd_pc's index SHALL increment if upd_taken (saturating at 2'b11) and decrement otherwise (saturating at 2'b00).
REQ-029 Update and lookup of the same index in one cycle: lookup SHALL use the pre-update value; the update takes effect on the next edge.
REQ-030 Update is independent of redirect and stall; upd_valid and redirect_valid in the same cycle are both applied.
REQ-031 out_pc, out_inst, out_pred_taken and out_pred_pc SHALL be don't-care while out_valid=0.

Reset
REQ-032 While rst_n=0 at a rising edge: pc <= RESET_PC; out_valid <= 0; out_pc, out_inst, out_pred_pc <= 0; out_pred_taken <= 0; all BHT counters <= 2'b01 (weakly not taken).
REQ-033 Reset SHALL override redirect and update in the same cycle; asserting reset mid-stall drops the held packet.
REQ-034 In the first cycle after reset release, imem_addr = RESET_PC and out_valid = 0.

Verification
REQ-035 Reset, out_ready=1, memory of NOPs (32'h00000013): imem_addr sequence 0,4,8; out_valid rises one cycle after release; out_pc trails imem_addr by one cycle.
REQ-036 JAL at 0x10 with imm +0x40: the next imem_addr is 0x50; out_pred_taken=1; out_pred_pc=0x50.
REQ-037 BEQ at 0x20 with imm -8 and a fresh BHT: predicted not taken (next 0x24); after two upd_taken=1 reports for 0x20, the next fetch of 0x20 is predicted taken to 0x18; after three not-taken reports, not taken again.
REQ-038 out_ready=0 for 3 cycles with out_valid=1: imem_addr and all out_* held; on out_ready=1, exactly one packet consumed and fetch resumes.
REQ-039 redirect_valid=1, redirect_pc=0x100 during a stall: the next cycle has out_valid=0 and imem_addr=0x100; the held packet is never delivered.
REQ-040 Branch at 0xFFFF_FFFC with positive imm 8 predicted taken: out_pred_pc = 0x0000_0004 (wrap); a counter already at 2'b11 receiving a taken update stays 2'b11.
